sfx_scheduler: RTL and testbench

SFX_SCHEDULER -- requirements
Module: sfx_scheduler

---
 rtl/sfx_scheduler.sv | 146 ++++++++++++++
 tb/tb_sfx_scheduler.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/sfx_scheduler.sv
// Priority voice scheduler for a bank of pcm players: start, retrigger, preempt or drop requests, and mix active voices.
// Optional build macro SFX_SCHED_DROP_STATS_EN adds a saturating 8-bit drop counter on drop_count_o.
module sfx_scheduler #(
  parameter int NUM_SFX      = 4,
  parameter int MAX_VOICES   = 2,
  parameter int SAMPLE_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_SFX-1:0]              trig_i,
  input  logic                            mute_i,
  input  logic [NUM_SFX-1:0]              busy_i,
  input  logic [NUM_SFX*SAMPLE_WIDTH-1:0] samples_i,
  output logic [NUM_SFX-1:0]              play_o,
  output logic [NUM_SFX-1:0]              stop_o,
  output logic [SAMPLE_WIDTH-1:0]         mix_o,
  output logic                            dropped_o,
  output logic [7:0]                      drop_count_o
);

  localparam int IDX_W = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1;
  localparam int CNT_W = $clog2(NUM_SFX + 1);
  localparam int SUM_W = SAMPLE_WIDTH + $clog2(NUM_SFX) + 1;

  typedef enum logic {IDLE, PREEMPT} state_e;

  state_e                  state_q;
  logic [NUM_SFX-1:0]      pending_q;
  logic [NUM_SFX-1:0]      play_q;
  logic [NUM_SFX-1:0]      stop_q;
  logic [SAMPLE_WIDTH-1:0] mix_q;
  logic                    dropped_q;
  logic [IDX_W-1:0]        pre_p_q;
  logic [IDX_W-1:0]        pre_v_q;

  logic [NUM_SFX-1:0]      pend_eff;
  logic [NUM_SFX-1:0]      active;
  logic [IDX_W-1:0]        p_idx;
  logic                    p_found;
  logic [IDX_W-1:0]        v_idx;
  logic [CNT_W-1:0]        act_cnt;
  logic                    voices_full;
  logic                    v_above;
  logic [SUM_W-1:0]        mix_sum;
  logic [SAMPLE_WIDTH-1:0] mix_d;

  // A voice whose play pulse is in flight counts as active before busy rises.
  assign pend_eff = pending_q | trig_i;
  assign active   = busy_i | play_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    p_idx   = '0;
    p_found = 1'b0;
    v_idx   = '0;
    act_cnt = '0;
    mix_sum = '0;
    for (int i = 0; i < NUM_SFX; i++) begin
      if (pend_eff[i] && !p_found) begin
        p_idx   = IDX_W'(i);
        p_found = 1'b1;
      end
      if (active[i]) v_idx = IDX_W'(i);
      act_cnt = act_cnt + CNT_W'(active[i]);
      if (busy_i[i]) mix_sum = mix_sum + SUM_W'(samples_i[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]);
    end
    voices_full = (act_cnt >= CNT_W'(MAX_VOICES));
    v_above     = (act_cnt != '0) && (v_idx > p_idx);
    mix_d       = (mix_sum > SUM_W'({SAMPLE_WIDTH{1'b1}})) ? {SAMPLE_WIDTH{1'b1}}
                                                          : mix_sum[SAMPLE_WIDTH-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments; later writes to a bit override the defaults above them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      play_q    <= '0;
      stop_q    <= '0;
      mix_q     <= '0;
      dropped_q <= 1'b0;
      pre_p_q   <= '0;
      pre_v_q   <= '0;
    end else begin
      play_q    <= '0;
      stop_q    <= '0;
      dropped_q <= 1'b0;
      mix_q     <= mix_d;
      if (mute_i) begin
        stop_q    <= busy_i;
        pending_q <= '0;
        state_q   <= IDLE;
      end else begin
        pending_q <= pend_eff;
        unique case (state_q)
          IDLE: begin
            if (p_found) begin
              if (active[p_idx] || !voices_full) begin
                play_q[p_idx]    <= 1'b1;
                pending_q[p_idx] <= 1'b0;
              end else if (v_above) begin
                stop_q[v_idx] <= 1'b1;
                pre_p_q       <= p_idx;
                pre_v_q       <= v_idx;
                state_q       <= PREEMPT;
              end else begin
                pending_q[p_idx] <= 1'b0;
                dropped_q        <= 1'b1;
              end
            end
          end
          PREEMPT: begin
            if (!busy_i[pre_v_q]) begin
              play_q[pre_p_q]    <= 1'b1;
              pending_q[pre_p_q] <= 1'b0;
              state_q            <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign play_o    = play_q;
  assign stop_o    = stop_q;
  assign mix_o     = mix_q;
  assign dropped_o = dropped_q;

`ifdef SFX_SCHED_DROP_STATS_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (dropped_q && drop_cnt_q != 8'hFF) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_count_o = drop_cnt_q;
`else
  assign drop_count_o = '0;
`endif

endmodule

// File: tb/tb_sfx_scheduler.sv
// Directed bench for sfx_scheduler (4 effects, 2 voices, 8-bit samples), hand-computed expectations.
module tb_sfx_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  trig;
  logic        mute;
  logic [3:0]  busy;
  logic [31:0] samples;
  logic [3:0]  play;
  logic [3:0]  stop;
  logic [7:0]  mix;
  logic        dropped;
  logic [7:0]  drop_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sfx_scheduler #(.NUM_SFX(4), .MAX_VOICES(2), .SAMPLE_WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .trig_i       (trig),
    .mute_i       (mute),
    .busy_i       (busy),
    .samples_i    (samples),
    .play_o       (play),
    .stop_o       (stop),
    .mix_o        (mix),
    .dropped_o    (dropped),
    .drop_count_o (drop_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge; outputs settle 1 ns later, well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulses(input string tag, input logic [3:0] exp_play, input logic [3:0] exp_stop,
                        input logic exp_drop);
    check({tag, ".play"}, 32'(play), 32'(exp_play));
    check({tag, ".stop"}, 32'(stop), 32'(exp_stop));
    check({tag, ".dropped"}, 32'(dropped), 32'(exp_drop));
  endtask

  initial begin
    rst_n = 1'b0; trig = '0; mute = 1'b0; busy = '0; samples = '0;
    tick(); tick();
    pulses("reset", 4'b0000, 4'b0000, 1'b0);
    check("reset.mix", 32'(mix), 32'h0);
    check("reset.drop_count", 32'(drop_count), 32'h0);
    rst_n = 1'b1;
    tick();

    // Single request from idle: one play pulse, minimum latency.
    trig = 4'b0100; tick(); trig = '0;
    pulses("single", 4'b0100, 4'b0000, 1'b0);
    tick();
    pulses("single_after", 4'b0000, 4'b0000, 1'b0);

    // Two requests in one cycle: serviced in priority order.
    trig = 4'b1010; tick(); trig = '0;
    pulses("pair_n1", 4'b0010, 4'b0000, 1'b0);
    tick();
    pulses("pair_n2", 4'b1000, 4'b0000, 1'b0);
    tick();
    pulses("pair_n3", 4'b0000, 4'b0000, 1'b0);

    // Retrigger an already playing effect.
    busy = 4'b0001; trig = 4'b0001; tick(); trig = '0;
    pulses("retrig", 4'b0001, 4'b0000, 1'b0);
    busy = '0; tick();

    // Preemption of the lowest-priority active voice.
    busy = 4'b0110; trig = 4'b0001; tick(); trig = '0;
    pulses("preempt_stop", 4'b0000, 4'b0100, 1'b0);
    tick();
    pulses("preempt_hold", 4'b0000, 4'b0000, 1'b0);
    busy = 4'b0010; tick();
    pulses("preempt_play", 4'b0001, 4'b0000, 1'b0);
    busy = '0; tick();
    pulses("preempt_done", 4'b0000, 4'b0000, 1'b0);

    // Drop when all voices outrank the request.
    busy = 4'b0011; trig = 4'b1000; tick(); trig = '0;
    pulses("drop", 4'b0000, 4'b0000, 1'b1);
    tick();
    check("drop_clear", 32'(dropped), 32'h0);
`ifdef SFX_SCHED_DROP_STATS_EN
    check("drop_count_1", 32'(drop_count), 32'd1);
`else
    check("drop_count_off", 32'(drop_count), 32'd0);
`endif
    trig = 4'b1000;
    for (int i = 0; i < 299; i++) tick();
    trig = '0; tick(); tick();
`ifdef SFX_SCHED_DROP_STATS_EN
    check("drop_count_sat", 32'(drop_count), 32'd255);
`else
    check("drop_count_off_300", 32'(drop_count), 32'd0);
`endif

    // Mix: busy voices only, saturating.
    busy = 4'b0011; samples = 32'h55_55_80_C0; tick();
    check("mix_sat", 32'(mix), 32'hFF);
    samples = 32'h55_55_20_C0; tick();
    check("mix_sum", 32'(mix), 32'hE0);
    busy = 4'b0000; tick();
    check("mix_idle", 32'(mix), 32'h00);
    samples = '0;

    // Mute during preemption: stop every busy voice, discard everything.
    busy = 4'b0110; trig = 4'b0001; tick(); trig = '0;
    pulses("mute_setup", 4'b0000, 4'b0100, 1'b0);
    mute = 1'b1; trig = 4'b1000; tick(); trig = '0;
    pulses("mute_stop", 4'b0000, 4'b0110, 1'b0);
    busy = 4'b0010; tick();
    pulses("mute_repeat", 4'b0000, 4'b0010, 1'b0);
    mute = 1'b0; busy = '0; tick();
    pulses("mute_release", 4'b0000, 4'b0000, 1'b0);
    tick();
    pulses("mute_idle", 4'b0000, 4'b0000, 1'b0);

    // Reset in the middle of a preemption abandons it.
    busy = 4'b0110; samples = 32'h00_40_40_00; trig = 4'b0001; tick(); trig = '0;
    pulses("rst_setup", 4'b0000, 4'b0100, 1'b0);
    check("rst_setup_mix", 32'(mix), 32'h80);
    rst_n = 1'b0; busy = '0; tick();
    pulses("rst_mid", 4'b0000, 4'b0000, 1'b0);
    check("rst_mid_mix", 32'(mix), 32'h0);
    check("rst_mid_drop_count", 32'(drop_count), 32'h0);
    rst_n = 1'b1; tick();
    pulses("rst_after", 4'b0000, 4'b0000, 1'b0);
    tick();
    pulses("rst_after2", 4'b0000, 4'b0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
